msk_and_hpc3o_seq: RTL and testbench

- Sequencer for the folded masked HPC3 AND gadget (control-indexed, `ina_prev` form).
- Accepts one pair of d-share operands per transaction, then issues NPASS gadget passes, one per fresh randomness word taken from the PRNG stream.
- Drives the gadget's one-cycle-late control index `s`, XOR-accumulates the gadget output shares, and returns the product sharing over a valid/ready handshake.
- Sits between the operand scheduler and one gadget instance.

---
 rtl/msk_and_hpc3o_seq.sv | 136 +++++++++++++
 tb/tb_msk_and_hpc3o_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/msk_and_hpc3o_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : msk_and_hpc3o_seq                                               |
// | Purpose  : Sequencer for a folded, control-indexed masked HPC3 AND gadget. |
// |            Captures one d-share operand pair, runs NPASS gadget passes    |
// |            (one fresh PRNG word each), XOR-accumulates the gadget output  |
// |            shares and returns the product sharing over valid/ready.       |
// | Ports    : clk, rst                  clock / sync active-high reset       |
// |            in_valid/in_ready/in_a/in_b    operand pair handshake         |
// |            rnd_valid/rnd_ready/rnd_in     PRNG stream                    |
// |            g_ina/g_ina_prev/g_inb/g_rnd/g_s  gadget drive               |
// |            g_out                          gadget output shares          |
// |            out_valid/out_ready/out_data   result sharing handshake      |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module msk_and_hpc3o_seq #(
  parameter int D          = 2,
  parameter int SHIDX_BITS = 3,
  parameter int NPASS      = D - 1,
  parameter int RW         = D * (D - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [D-1:0]          in_a,
  input  logic [D-1:0]          in_b,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  input  logic [RW-1:0]         rnd_in,
  output logic [D-1:0]          g_ina,
  output logic [D-1:0]          g_ina_prev,
  output logic [D-1:0]          g_inb,
  output logic [RW-1:0]         g_rnd,
  output logic [SHIDX_BITS-1:0] g_s,
  input  logic [D-1:0]          g_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [D-1:0]          out_data
);

  localparam logic [SHIDX_BITS-1:0] c_k_last = SHIDX_BITS'(NPASS - 1);
  localparam logic [SHIDX_BITS-1:0] c_one    = SHIDX_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [D-1:0]            r_a;
  logic [D-1:0]            r_b;
  logic [D-1:0]            r_acc;
  logic [SHIDX_BITS-1:0]   r_k;
  logic [SHIDX_BITS-1:0]   r_s;
  logic                    r_fired;
  logic                    r_out_valid;
  logic                    w_in_ready;
  logic                    w_fire;

  // Next-state and handshake decode. rst forces every strobe low so nothing
  // is accepted, consumed or spent in a reset cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_fire = rnd_valid;
        if (rnd_valid && (r_k == c_k_last)) w_state_nxt = S_DRAIN;
      end
      // One cycle for the gadget output of the final pass to be absorbed.
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst) begin
      w_in_ready = 1'b0;
      w_fire     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_k         <= '0;
      r_s         <= '0;
      r_fired     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt == S_DONE);
      // The gadget control is latency-1: the pass index follows its rnd word
      // by one cycle and is zero on any cycle after a stall, which silences
      // every cross term so the accumulator sees g_out = 0.
      r_fired     <= w_fire;
      r_s         <= w_fire ? (r_k + c_one) : '0;
      if (r_fired) r_acc <= r_acc ^ g_out;
      if ((r_state == S_IDLE) && in_valid) begin
        r_a   <= in_a;
        r_b   <= in_b;
        r_acc <= '0;
        r_k   <= '0;
      end else if (w_fire && (r_k != c_k_last)) begin
        r_k <= r_k + c_one;
      end
    end
  end

  // Operands are held from capture to the next IDLE, so ina_prev (previous
  // cycle's ina) is simply the same register.
  assign g_ina      = rst ? '0 : r_a;
  assign g_ina_prev = rst ? '0 : r_a;
  assign g_inb      = rst ? '0 : r_b;
  // Randomness is only exposed on a consuming cycle.
  assign g_rnd      = w_fire ? rnd_in : '0;
  assign g_s        = r_s;
  assign rnd_ready  = w_fire;
  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid & ~rst;
  assign out_data   = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_msk_and_hpc3o_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_msk_and_hpc3o_seq                                            |
// | Purpose  : Self-checking bench for msk_and_hpc3o_seq (d=3) with a         |
// |            behavioural folded gadget and a spec-level reference model.     |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_msk_and_hpc3o_seq;

  localparam int D          = 3;
  localparam int SHIDX_BITS = 3;
  localparam int NPASS      = D - 1;
  localparam int RW         = D * (D - 1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [D-1:0]          in_a;
  logic [D-1:0]          in_b;
  logic                  rnd_valid;
  logic                  rnd_ready;
  logic [RW-1:0]         rnd_in;
  logic [D-1:0]          g_ina;
  logic [D-1:0]          g_ina_prev;
  logic [D-1:0]          g_inb;
  logic [RW-1:0]         g_rnd;
  logic [SHIDX_BITS-1:0] g_s;
  logic [D-1:0]          g_out;
  logic                  out_valid;
  logic                  out_ready;
  logic [D-1:0]          out_data;
  logic [RW-1:0]         r_gad_rnd;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  msk_and_hpc3o_seq #(
    .D          (D),
    .SHIDX_BITS (SHIDX_BITS),
    .NPASS      (NPASS),
    .RW         (RW)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .rnd_in     (rnd_in),
    .g_ina      (g_ina),
    .g_ina_prev (g_ina_prev),
    .g_inb      (g_inb),
    .g_rnd      (g_rnd),
    .g_s        (g_s),
    .g_out      (g_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  // Folded gadget: randomness is registered (latency 1, aligned with s).
  // Pass s=j yields the cross products a_i & b_(i+j mod d); pass 1 also
  // carries the diagonal. Over passes 1..d-1 every a_i&b_k pair appears once,
  // masked by r_i ^ r_(i+1) which cancels in the unmasked sum. s=0 gives 0.
  always @(posedge clk) r_gad_rnd <= g_rnd;

  always_comb begin
    g_out = '0;
    for (int i = 0; i < D; i++) begin
      if ((g_s != '0) && (int'(g_s) < D)) begin
        g_out[i] = (g_ina_prev[i] & g_inb[(i + int'(g_s)) % D])
                   ^ r_gad_rnd[i] ^ r_gad_rnd[(i + 1) % D];
        if (g_s == SHIDX_BITS'(1)) g_out[i] = g_out[i] ^ (g_ina_prev[i] & g_inb[i]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One full transaction. mode 0: rnd always valid; 1: rnd pattern 1,0,0,1;
  // 2: random rnd stalls. bp = extra DONE cycles with out_ready low.
  // lat = cycles from accept to first out_valid.
  task automatic run_txn(input logic [D-1:0] a, input logic [D-1:0] b,
                         input int mode, input int bp, output int lat);
    int fired, last_fire, cyc_n, nrnd, to;
    logic exp_fire, exp_ov, rv;
    logic [SHIDX_BITS-1:0] exp_s;
    logic [D-1:0] held;
    in_a = a; in_b = b; in_valid = 1'b1; rnd_valid = 1'b0; out_ready = 1'b0;
    #1;
    to = 0;
    while (!in_ready && to < 20) begin @(posedge clk); #2; to++; end
    chk("accept_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = D'($urandom); in_b = D'($urandom);
    fired = 0; last_fire = 0; nrnd = 0; exp_s = '0;
    for (cyc_n = 1; cyc_n <= 200; cyc_n++) begin
      case (mode)
        0:       rv = 1'b1;
        1:       rv = (cyc_n == 2 || cyc_n == 3) ? 1'b0 : 1'b1;
        default: rv = ($urandom_range(0, 3) != 0);
      endcase
      rnd_valid = rv; rnd_in = RW'($urandom);
      #1;
      exp_ov = (fired == NPASS) && (cyc_n == last_fire + 2);
      chk("out_valid", out_valid, exp_ov);
      chk("g_s", g_s, exp_s);
      if (out_valid || exp_ov) break;
      exp_fire = rv && (fired < NPASS);
      chk("rnd_ready", rnd_ready, exp_fire);
      chk("g_rnd", g_rnd, exp_fire ? rnd_in : '0);
      chk("in_ready_busy", in_ready, 0);
      chk("g_operands", {g_ina, g_ina_prev, g_inb}, {a, a, b});
      if (rnd_ready) nrnd++;
      exp_s = exp_fire ? SHIDX_BITS'(fired + 1) : '0;
      if (exp_fire) begin fired++; last_fire = cyc_n; end
      @(posedge clk); #1;
    end
    chk("run_timeout", (cyc_n <= 200) ? 1 : 0, 1);
    lat = cyc_n;
    held = out_data;
    for (int i = 0; i < bp; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, held);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_rnd_ready", rnd_ready, 0);
      if (rnd_ready) nrnd++;
      @(posedge clk); #1;
      rnd_valid = 1'b1; rnd_in = RW'($urandom);
      #1;
    end
    out_ready = 1'b1; #1;
    chk("hs_out_valid", out_valid, 1);
    chk("hs_out_data", out_data, held);
    chk("result", ^out_data, (^a) & (^b));
    chk("rnd_count", nrnd, NPASS);
    @(posedge clk); #1;
    out_ready = 1'b0; rnd_valid = 1'b0; #1;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b1; in_a = '1; in_b = '1;
    rnd_valid = 1'b1; rnd_in = '1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rnd_ready", rnd_ready, 0);
    chk("rst_g_rnd", g_rnd, 0);
    chk("rst_operands", {g_ina, g_ina_prev, g_inb}, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_g_s", g_s, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; rnd_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_rnd_ready", rnd_ready, 0);
      chk("idle_g_s", g_s, 0);
      chk("idle_out_valid", out_valid, 0);
      @(posedge clk); #1;
    end

    run_txn(3'b101, 3'b011, 0, 0, lat);
    chk("lat_nostall_0", lat, NPASS + 2);
    run_txn(3'b100, 3'b001, 0, 0, lat);
    chk("lat_nostall_1", lat, NPASS + 2);
    run_txn(3'b100, 3'b001, 1, 0, lat);
    chk("lat_stall", lat, NPASS + 4);
    run_txn(3'b111, 3'b111, 0, 5, lat);
    chk("lat_bp", lat, NPASS + 2);

    // Reset while in RUN after one pass has fired.
    in_a = 3'b110; in_b = 3'b011; in_valid = 1'b1; rnd_valid = 1'b0; #1;
    chk("mr_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b1; rnd_in = RW'($urandom); #1;
    chk("mr_fire", rnd_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("mr_rst_rnd_ready", rnd_ready, 0);
    chk("mr_rst_g_rnd", g_rnd, 0);
    chk("mr_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0; rnd_valid = 1'b0; #1;
    chk("mr_idle_in_ready", in_ready, 1);
    chk("mr_idle_g_s", g_s, 0);
    chk("mr_idle_out_valid", out_valid, 0);
    chk("mr_acc_clear", out_data, 0);
    run_txn(3'b110, 3'b011, 0, 0, lat);
    chk("mr_lat", lat, NPASS + 2);

    for (int t = 0; t < 1000; t++) begin
      run_txn(D'($urandom), D'($urandom), 2, $urandom_range(0, 3), lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
